// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared UART clocking defaults and receiver state encoding
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int CLOCK_FREQUENCY_DEFAULT = 27000000;
  localparam int BAUD_RATE_DEFAULT       = 115200;

  function automatic int baud_divisor(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync : two-flop synchronizer for an asynchronous single-bit input
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver with valid/ready output, framing and overrun
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx #(
  parameter int CLOCK_FREQUENCY = uart_pkg::CLOCK_FREQUENCY_DEFAULT,
  parameter int BAUD_RATE       = uart_pkg::BAUD_RATE_DEFAULT,
  parameter int BAUD_DIVISOR    = uart_pkg::baud_divisor(CLOCK_FREQUENCY, BAUD_RATE),
  parameter int HALF_DIVISOR    = BAUD_DIVISOR / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       framing_error,
  output logic       overrun
);

  import uart_pkg::*;

  localparam logic [7:0] BIT_LAST  = 8'(BAUD_DIVISOR - 1);
  localparam logic [7:0] HALF_LAST = 8'(HALF_DIVISOR - 1);

  rx_state_t  state, state_next;
  logic       rx_s;
  logic [7:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;

  logic       cnt_clear;
  logic       sample_bit;
  logic       deliver;
  logic       frame_err;

  uart_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    sample_bit = 1'b0;
    deliver    = 1'b0;
    frame_err  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          state_next = RX_START;
          cnt_clear  = 1'b1;
        end
      end
      RX_START: begin
        // Centre of the start bit: a high line here means it was only a glitch.
        if (cnt == HALF_LAST) begin
          cnt_clear  = 1'b1;
          state_next = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_clear  = 1'b1;
          sample_bit = 1'b1;
          if (bit_idx == 3'd7) state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_clear = 1'b1;
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = RX_IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_s) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 8'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
    end else begin
      if (cnt_clear)
        cnt <= 8'd0;
      else if (state == RX_START || state == RX_DATA || state == RX_STOP)
        cnt <= cnt + 8'd1;
      else
        cnt <= 8'd0;

      if (state == RX_START)
        bit_idx <= 3'd0;
      else if (sample_bit)
        bit_idx <= bit_idx + 3'd1;

      // LSB arrives first, so shifting in at the MSB leaves bit0 at shift[0].
      if (sample_bit)
        shift <= {rx_s, shift[7:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data          <= 8'd0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= frame_err;
      overrun       <= deliver && valid && !ready;
      if (deliver && (!valid || ready)) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign busy = (state != RX_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : randomized scoreboard bench for uart_rx
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  localparam int EV_DATA = 0;
  localparam int EV_FE   = 1;
  localparam int EV_OVR  = 2;
  localparam int DIV     = 234;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       framing_error;
  logic       overrun;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  fall_cyc = 0;
  int  valid_rise_cyc = -1;

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .busy         (busy),
    .framing_error(framing_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void expect_ev(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic got(input int kind, input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data 0x%02h, expected none", kind, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_DATA && e.data !== d)) begin
        errors++;
        $display("FAIL scoreboard: got kind %0d data 0x%02h, expected kind %0d data 0x%02h",
                 kind, d, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every observable output event is matched against the queue.
  logic prev_valid = 1'b0;
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (valid === 1'b1 && prev_valid !== 1'b1) valid_rise_cyc = cyc;
      if (framing_error !== 1'b0) got(EV_FE, 8'h00);
      if (overrun !== 1'b0)       got(EV_OVR, 8'h00);
      if (valid === 1'b1 && ready === 1'b1) got(EV_DATA, data);
    end
    prev_valid = valid;
  end

  // All driving happens at negedges; each task starts and ends on one.
  task automatic send_frame(input logic [7:0] b, input int div, input logic stop_bit);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (div) @(negedge clk);
    end
    rx = stop_bit;
    repeat (div) @(negedge clk);
  endtask

  // Reference model with ready held high: good stop -> byte, bad stop -> framing error.
  task automatic issue(input logic [7:0] b, input int div, input logic stop_bit);
    if (stop_bit) expect_ev(EV_DATA, b);
    else          expect_ev(EV_FE, 8'h00);
    send_frame(b, div, stop_bit);
    if (!stop_bit) begin
      rx = 1'b1;
      repeat (5) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] pat [3];
    int         divs [3];
    int         lat;
    int         waitc;
    pat[0] = 8'hFF; pat[1] = 8'h00; pat[2] = 8'h5A;
    divs[0] = 229;  divs[1] = 234;  divs[2] = 239;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_framing_error", {31'd0, framing_error}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    repeat (5) @(negedge clk);

    // Single byte, ready high: check data and pin-to-valid latency.
    issue(8'h55, DIV, 1'b1);
    lat = valid_rise_cyc - fall_cyc;
    chk("latency_0x55", lat, 32'd2226);
    chk("valid_one_cycle", {31'd0, valid}, 32'd0);

    // Overrun: second byte dropped while first is still unaccepted.
    ready = 1'b0;
    expect_ev(EV_OVR, 8'h00);
    expect_ev(EV_DATA, 8'hA3);
    send_frame(8'hA3, DIV, 1'b1);
    send_frame(8'h00, DIV, 1'b1);
    repeat (5) @(negedge clk);
    chk("held_valid", {31'd0, valid}, 32'd1);
    chk("held_data", {24'd0, data}, 32'hA3);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    #1;
    chk("valid_cleared", {31'd0, valid}, 32'd0);
    @(negedge clk);
    ready = 1'b1;
    repeat (10) @(negedge clk);

    // Short low glitch is rejected at the start-bit centre.
    rx = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_busy_high", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (130) @(negedge clk);
    chk("glitch_busy_low", {31'd0, busy}, 32'd0);

    // Framing error followed by a long break.
    expect_ev(EV_FE, 8'h00);
    send_frame(8'h3C, DIV, 1'b0);
    repeat (5000) @(negedge clk);
    chk("break_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    @(negedge clk);
    chk("break_release_busy_1", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    chk("break_release_busy_0", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clk);

    // Reset in the middle of bit 4 of 0xF0.
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_data", {24'd0, data}, 32'd0);
    chk("midreset_valid", {31'd0, valid}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_framing_error", {31'd0, framing_error}, 32'd0);
    chk("midreset_overrun", {31'd0, overrun}, 32'd0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    issue(8'h81, DIV, 1'b1);

    // Baud tolerance at roughly +/-2%.
    for (int d = 0; d < 3; d += 2) begin
      for (int p = 0; p < 3; p++) begin
        issue(pat[p], divs[d], 1'b1);
      end
    end

    // Randomized frames, gaps, bit rates and occasional bad stop bits.
    for (int n = 0; n < 12; n++) begin
      issue(8'($urandom_range(0, 255)), divs[$urandom_range(0, 2)],
            ($urandom_range(0, 5) != 0));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    waitc = 0;
    while (exp_q.size() != 0 && waitc < 3000) begin
      @(negedge clk);
      waitc++;
    end
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
